// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall sequencer: FSM state encoding
// and the PC source select codes.
package pa_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_IMISS = 2'd1,
    S_DMISS = 2'd2,
    S_MUL   = 2'd3
  } ctrl_state_t;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_EXC = 2'd2;

endpackage

// File: rtl/pipeline_ctrl_stall_counter.sv
// Saturating down-counter that times the multi-cycle multiply hold.
// Supports load, decrement, clear and exposes a zero flag.
module stall_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer for the 5-stage core: drives write enables and
// synchronous clears of the PC and the four inter-stage registers.
module pipeline_ctrl
  import pa_pkg::*;
#(
  parameter int MUL_LAT = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       icache_miss,
  input  logic       icache_ready,
  input  logic       dcache_miss,
  input  logic       dcache_ready,
  input  logic       mul_start,
  input  logic       load_use,
  input  logic       branch_taken,
  input  logic       exception,
  output logic       pc_wr,
  output logic [1:0] pc_sel,
  output logic       wr_if_id,
  output logic       wr_id_ex,
  output logic       wr_ex_mem,
  output logic       wr_mem_wb,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       flush_ex_mem,
  output logic       flush_mem_wb,
  output logic       busy
);

  localparam int CW = $clog2(MUL_LAT);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 2);

  ctrl_state_t state_q;
  ctrl_state_t state_d;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_clr;
  logic        cnt_zero;
  logic        imiss_act;

  stall_counter #(.W(CW)) u_stall_counter (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (MUL_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // An outstanding fetch miss keeps stalling until its data returns.
  assign imiss_act = (state_q == S_RUN) ? icache_miss : ~icache_ready;

  // NOTE: every output and next-state signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_clr      = 1'b0;
    pc_wr        = 1'b1;
    pc_sel       = PC_SEQ;
    wr_if_id     = 1'b1;
    wr_id_ex     = 1'b1;
    wr_ex_mem    = 1'b1;
    wr_mem_wb    = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;

    if (reset) begin
      state_d      = S_RUN;
      cnt_clr      = 1'b1;
      pc_wr        = 1'b0;
      wr_if_id     = 1'b0;
      wr_id_ex     = 1'b0;
      wr_ex_mem    = 1'b0;
      wr_mem_wb    = 1'b0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
    end else if (exception) begin
      state_d      = S_RUN;
      cnt_clr      = 1'b1;
      pc_sel       = PC_EXC;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
    end else begin
      case (state_q)
        S_DMISS: begin
          if (dcache_ready) begin
            state_d = S_RUN;
          end else begin
            pc_wr        = 1'b0;
            wr_if_id     = 1'b0;
            wr_id_ex     = 1'b0;
            wr_ex_mem    = 1'b0;
            flush_mem_wb = 1'b1;
          end
        end
        S_MUL: begin
          if (dcache_miss) begin
            // EX/MEM is held, so the multiply result survives the data miss.
            state_d      = S_DMISS;
            cnt_clr      = 1'b1;
            pc_wr        = 1'b0;
            wr_if_id     = 1'b0;
            wr_id_ex     = 1'b0;
            wr_ex_mem    = 1'b0;
            flush_mem_wb = 1'b1;
          end else if (!cnt_zero) begin
            cnt_dec      = 1'b1;
            pc_wr        = 1'b0;
            wr_if_id     = 1'b0;
            wr_id_ex     = 1'b0;
            flush_ex_mem = 1'b1;
          end else begin
            state_d = S_RUN;
            cnt_clr = 1'b1;
          end
        end
        default: begin
          if (dcache_miss) begin
            state_d      = S_DMISS;
            pc_wr        = 1'b0;
            wr_if_id     = 1'b0;
            wr_id_ex     = 1'b0;
            wr_ex_mem    = 1'b0;
            flush_mem_wb = 1'b1;
          end else if (mul_start) begin
            state_d      = S_MUL;
            cnt_load     = 1'b1;
            pc_wr        = 1'b0;
            wr_if_id     = 1'b0;
            wr_id_ex     = 1'b0;
            flush_ex_mem = 1'b1;
          end else if (branch_taken) begin
            // Redirect abandons any in-flight fetch, including a load-use victim in ID.
            state_d     = S_RUN;
            pc_sel      = PC_BR;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else begin
            if (load_use) begin
              pc_wr       = 1'b0;
              wr_if_id    = 1'b0;
              flush_id_ex = 1'b1;
            end else if (imiss_act) begin
              pc_wr       = 1'b0;
              flush_if_id = 1'b1;
            end
            if (state_q == S_RUN) begin
              state_d = icache_miss ? S_IMISS : S_RUN;
            end else begin
              state_d = icache_ready ? S_RUN : S_IMISS;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q != S_RUN);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with hand-derived
// expectations plus a randomized run against a flag-based behavioural model.
module tb_pipeline_ctrl;

  localparam int MUL_LAT = 5;

  logic       clk;
  logic       reset;
  logic       icache_miss, icache_ready, dcache_miss, dcache_ready;
  logic       mul_start, load_use, branch_taken, exception;
  logic       pc_wr;
  logic [1:0] pc_sel;
  logic       wr_if_id, wr_id_ex, wr_ex_mem, wr_mem_wb;
  logic       flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Observation vector: {busy, pc_wr, pc_sel, wr[if_id,id_ex,ex_mem,mem_wb], flush[same order]}
  logic [11:0] obs;
  assign obs = {busy, pc_wr, pc_sel, wr_if_id, wr_id_ex, wr_ex_mem, wr_mem_wb,
                flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};

  pipeline_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .icache_miss  (icache_miss),
    .icache_ready (icache_ready),
    .dcache_miss  (dcache_miss),
    .dcache_ready (dcache_ready),
    .mul_start    (mul_start),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .exception    (exception),
    .pc_wr        (pc_wr),
    .pc_sel       (pc_sel),
    .wr_if_id     (wr_if_id),
    .wr_id_ex     (wr_id_ex),
    .wr_ex_mem    (wr_ex_mem),
    .wr_mem_wb    (wr_mem_wb),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .flush_ex_mem (flush_ex_mem),
    .flush_mem_wb (flush_mem_wb),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [11:0] mk(logic b, logic p, logic [1:0] s, logic [3:0] w, logic [3:0] f);
    return {b, p, s, w, f};
  endfunction

  task automatic clear_in();
    icache_miss = 0; icache_ready = 0; dcache_miss = 0; dcache_ready = 0;
    mul_start = 0; load_use = 0; branch_taken = 0; exception = 0;
  endtask

  // Behavioural model: outstanding-event flags plus an absolute release cycle for the multiply.
  typedef enum {C_NONE, C_DM, C_MUL, C_BR, C_LU, C_IM} cause_t;
  bit m_dmiss, m_mul, m_imiss;
  int m_mul_end;
  int cyc = 0;

  function automatic logic [11:0] model_exp();
    logic   b;
    cause_t c;
    b = m_dmiss | m_mul | m_imiss;
    if (reset) return mk(b, 0, 2'd0, 4'b0000, 4'b1111);
    if (exception) return mk(b, 1, 2'd2, 4'b1111, 4'b1111);
    if (m_dmiss)          c = dcache_ready ? C_NONE : C_DM;
    else if (m_mul)       c = dcache_miss ? C_DM : ((cyc < m_mul_end) ? C_MUL : C_NONE);
    else if (dcache_miss) c = C_DM;
    else if (mul_start)   c = C_MUL;
    else if (branch_taken) c = C_BR;
    else if (load_use)    c = C_LU;
    else if (m_imiss ? !icache_ready : icache_miss) c = C_IM;
    else                  c = C_NONE;
    case (c)
      C_DM:    return mk(b, 0, 2'd0, 4'b0001, 4'b0001);
      C_MUL:   return mk(b, 0, 2'd0, 4'b0011, 4'b0010);
      C_BR:    return mk(b, 1, 2'd1, 4'b1111, 4'b1100);
      C_LU:    return mk(b, 0, 2'd0, 4'b0111, 4'b0100);
      C_IM:    return mk(b, 0, 2'd0, 4'b1111, 4'b1000);
      default: return mk(b, 1, 2'd0, 4'b1111, 4'b0000);
    endcase
  endfunction

  task automatic model_step();
    if (reset || exception) begin
      m_dmiss = 0; m_mul = 0; m_imiss = 0;
    end else if (m_dmiss) begin
      if (dcache_ready) m_dmiss = 0;
    end else if (m_mul) begin
      if (dcache_miss) begin
        m_mul = 0; m_dmiss = 1;
      end else if (cyc >= m_mul_end) begin
        m_mul = 0;
      end
    end else if (dcache_miss) begin
      m_dmiss = 1; m_imiss = 0;
    end else if (mul_start) begin
      m_mul = 1; m_mul_end = cyc + MUL_LAT - 1; m_imiss = 0;
    end else if (branch_taken) begin
      m_imiss = 0;
    end else if (m_imiss) begin
      m_imiss = !icache_ready;
    end else begin
      m_imiss = icache_miss;
    end
    cyc++;
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    clear_in();
    reset = 1;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      exp = mk(0, 0, 2'd0, 4'b0000, 4'b1111);
      @(negedge clk); checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset c%0d got=%b exp=%b", c, obs, exp); end
      @(posedge clk); #1;
    end
    reset = 0;
    for (int c = 0; c < 2; c++) begin
      exp = mk(0, 1, 2'd0, 4'b1111, 4'b0000);
      @(negedge clk); checks++;
      if (obs !== exp) begin errors++; $display("FAIL idle c%0d got=%b exp=%b", c, obs, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dmiss();
    logic [11:0] exp;
    for (int c = 0; c < 7; c++) begin
      dcache_miss  = (c == 0);
      dcache_ready = (c == 5);
      if (c < 5)       exp = mk(c != 0, 0, 2'd0, 4'b0001, 4'b0001);
      else if (c == 5) exp = mk(1, 1, 2'd0, 4'b1111, 4'b0000);
      else             exp = mk(0, 1, 2'd0, 4'b1111, 4'b0000);
      @(negedge clk); checks++;
      if (obs !== exp) begin errors++; $display("FAIL dmiss c%0d got=%b exp=%b", c, obs, exp); end
      @(posedge clk); #1;
    end
    clear_in();
  endtask

  task automatic test_mul();
    logic [11:0] exp;
    for (int c = 0; c < 6; c++) begin
      mul_start = (c == 0);
      if (c < MUL_LAT - 1)       exp = mk(c != 0, 0, 2'd0, 4'b0011, 4'b0010);
      else if (c == MUL_LAT - 1) exp = mk(1, 1, 2'd0, 4'b1111, 4'b0000);
      else                       exp = mk(0, 1, 2'd0, 4'b1111, 4'b0000);
      @(negedge clk); checks++;
      if (obs !== exp) begin errors++; $display("FAIL mul c%0d got=%b exp=%b", c, obs, exp); end
      @(posedge clk); #1;
    end
    clear_in();
  endtask

  task automatic test_branch_load_use();
    logic [11:0] exp;
    load_use = 1; branch_taken = 1;
    exp = mk(0, 1, 2'd1, 4'b1111, 4'b1100);
    @(negedge clk); checks++;
    if (obs !== exp) begin errors++; $display("FAIL br_lu got=%b exp=%b", obs, exp); end
    @(posedge clk); #1;
    load_use = 1; branch_taken = 0;
    exp = mk(0, 0, 2'd0, 4'b0111, 4'b0100);
    @(negedge clk); checks++;
    if (obs !== exp) begin errors++; $display("FAIL lu_only got=%b exp=%b", obs, exp); end
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic test_exception_in_dmiss();
    logic [11:0] exp;
    for (int c = 0; c < 3; c++) begin
      dcache_miss = (c == 0);
      exception   = (c == 1);
      if (c == 0)      exp = mk(0, 0, 2'd0, 4'b0001, 4'b0001);
      else if (c == 1) exp = mk(1, 1, 2'd2, 4'b1111, 4'b1111);
      else             exp = mk(0, 1, 2'd0, 4'b1111, 4'b0000);
      @(negedge clk); checks++;
      if (obs !== exp) begin errors++; $display("FAIL exc_dmiss c%0d got=%b exp=%b", c, obs, exp); end
      @(posedge clk); #1;
    end
    clear_in();
  endtask

  task automatic test_imiss_branch();
    logic [11:0] exp_tab [5];
    exp_tab[0] = mk(0, 0, 2'd0, 4'b1111, 4'b1000);
    exp_tab[1] = mk(1, 1, 2'd1, 4'b1111, 4'b1100);
    exp_tab[2] = mk(0, 0, 2'd0, 4'b1111, 4'b1000);
    exp_tab[3] = mk(1, 1, 2'd0, 4'b1111, 4'b0000);
    exp_tab[4] = mk(0, 1, 2'd0, 4'b1111, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      icache_miss  = (c < 3);
      branch_taken = (c == 1);
      icache_ready = (c == 3);
      @(negedge clk); checks++;
      if (obs !== exp_tab[c]) begin
        errors++; $display("FAIL imiss_br c%0d got=%b exp=%b", c, obs, exp_tab[c]);
      end
      @(posedge clk); #1;
    end
    clear_in();
  endtask

  task automatic test_random();
    logic [11:0] exp;
    clear_in();
    reset = 1;
    @(negedge clk);
    @(posedge clk); #1;
    m_dmiss = 0; m_mul = 0; m_imiss = 0;
    reset = 0;
    for (int c = 0; c < 500; c++) begin
      reset        = ($urandom_range(0, 79) == 0);
      exception    = ($urandom_range(0, 31) == 0);
      dcache_miss  = ($urandom_range(0, 7) == 0);
      dcache_ready = ($urandom_range(0, 2) == 0);
      mul_start    = ($urandom_range(0, 7) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      load_use     = ($urandom_range(0, 5) == 0);
      icache_miss  = ($urandom_range(0, 4) == 0);
      icache_ready = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      exp = model_exp();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL random c%0d got=%b exp=%b", c, obs, exp); end
      @(posedge clk);
      model_step();
      #1;
    end
    reset = 0;
    clear_in();
  endtask

  initial begin
    test_reset();
    test_dmiss();
    test_mul();
    test_branch_load_use();
    test_exception_in_dmiss();
    test_imiss_branch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
